poly_synthesizer: RTL
=====================

# poly_synthesizer

Polyphonic, parametrised successor to the single-voice sample player. It runs `VOICES` independent sample-playback voices, each with its own note, pitch prescaler and position. All voices share one external sample ROM through a round-robin, time-multiplexed read port. Once per frame the block emits a saturated signed mix that drives the existing PWM output stage.

## Interface
- `VOICES`, 4: number of voices; power of two, 2..16.
- `POS_W`, 15: sample ROM address width.
- `SAMPLE_W`, 8: signed sample width; also the width of `mix_out`.
- `PRESC_W`, 16: width of the per-voice prescaler counter.
- `LOOP`, 0: 0 = a voice stops at the end of its sample region; 1 = the voice wraps to the region base.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  start or retrigger voice `voice` with `note`.
- `stop`  in  1  stop voice `voice`.
- `voice`  in  $clog2(VOICES)  target voice for `start`/`stop`.
- `note`  in  7  bits [6:4] octave, [3:2] sample, [1:0] pitch step.
- `rom_addr`  out  POS_W  registered ROM read address.
- `rom_data`  in  SAMPLE_W  signed ROM data, valid the cycle after `rom_addr`.
- `mix_out`  out  SAMPLE_W  signed saturated mix, held between frames.
- `mix_valid`  out  1  one-cycle pulse when `mix_out` updates.
- `active`  out  VOICES  per-voice playing flag.

## Operation
- Per-voice state: `playing`, `pos[POS_W]`, `end[POS_W]`, `base[POS_W]`, `presc[PRESC_W]`, `cnt[PRESC_W]`.
- Voice FSM states: IDLE and PLAY.
- On `start`, the target voice enters PLAY:
  - region index = {note[4], note[3:2]}; codes 000, 011 and 111 map to region 0;
  - `pos` and `base` load the region base; `end` = base + length − 1;
  - `cnt` = 0; `presc` = table[note[1:0]] = 12714 / 12000 / 11327 / 10691.
- `stop` forces IDLE. If `start` and `stop` arrive in the same cycle, `stop` wins.
- `start` to a voice already playing is a retrigger: full reload, no glitch handling.
- In PLAY, every cycle:
  - if `cnt == presc`: `cnt` = 0 and `pos` advances;
  - otherwise `cnt` increments.
- Advance rule:
  - if `pos != end`: `pos + 1`;
  - if `pos == end` and LOOP=0: the voice goes IDLE and `pos` holds;
  - if `pos == end` and LOOP=1: `pos` = `base`.
- Slot counter `slot` cycles 0..VOICES−1, one step per clock.
- In slot s: `rom_addr` ← pos[s] and `act_d` ← playing[s].
- The cycle after slot s, the accumulator adds `rom_data` if `act_d` = 1, else adds 0.
- Accumulator width is SAMPLE_W + $clog2(VOICES) bits, signed. It clears at the start of every frame.
- After voice VOICES−1 has been added, `mix_out` ← sum saturated to [−2^(SAMPLE_W−1), 2^(SAMPLE_W−1)−1].
- `active` = the `playing` vector, registered.

## Timing
- Reset values: all voices IDLE; `pos`, `base`, `end`, `cnt`, `presc` = 0; `slot` = 0; `rom_addr` = 0; accumulator = 0; `mix_out` = 0; `mix_valid` = 0; `active` = 0.
- Reset mid-frame: the partial sum is discarded. The first `mix_valid` after reset release comes VOICES+1 cycles later.
- `start`/`stop` sampled at edge N: `active` changes at edge N+1. The new `pos` is visible to the slot read at edge N+1 onward.
- Frame period is VOICES cycles; `mix_valid` pulses every VOICES cycles.
- Latency: a voice's position read in slot s reaches `mix_out` at most VOICES+1 cycles later.
- Per-voice step period is presc+1 clocks, independent of the slot schedule.
- The ROM must be synchronous with exactly one cycle of read latency.

## Structure
- Header `synth_pkg.vh` holds:
  - region base/length constants (6 regions, replacing the `SAMPLE_*` defines);
  - the 4-entry prescaler table;
  - the region-index decode function.
- Sub-module `synth_voice`, instantiated VOICES times via generate, contains the voice FSM, prescaler and position logic.
- The top level holds the slot mux, ROM port, accumulator and saturation.

## Test plan
- Reset mid-play: `rst` during PLAY → every output returns to 0 on the same cycle, asynchronously.
- Single start: start voice 0, note 7'b000_01_00 → `active` = 0001 next edge; `rom_addr` in slot 0 equals region-1 base; `pos` advances once every 12715 cycles.
- Saturation: four voices on a ROM model returning +100 → `mix_out` = +127; ROM returning −100 → `mix_out` = −128; `mix_valid` every 4 cycles.
- Start/stop collision: `start` and `stop` together on a playing voice 2 → voice 2 IDLE; its slot contributes 0 to the next frame.
- End of region, LOOP=0: with a 4-sample test region, voice 1 → `active[1]` drops after 4 × (presc+1) cycles; `pos` holds at `end`.
- End of region, LOOP=1: same setup → `pos` wraps to `base` and `active[1]` stays 1.
- Retrigger: a second `start` on a playing voice with pitch step 3 → `pos` reloads to base, `cnt` = 0, period becomes 10692 cycles.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared constants for the polyphonic sample player: ROM region map,
// pitch prescaler table and the note-to-region decode.
package synth_pkg;

    typedef enum logic {V_IDLE, V_PLAY} voice_state_t;

    // Codes 000, 011 and 111 have no region of their own and fall back to region 0.
    function automatic logic [2:0] region_index(input logic [2:0] code);
        case (code)
            3'b001:  return 3'd1;
            3'b010:  return 3'd2;
            3'b100:  return 3'd3;
            3'b101:  return 3'd4;
            3'b110:  return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic int unsigned region_base(input logic [2:0] r);
        case (r)
            3'd1:    return 4096;
            3'd2:    return 8192;
            3'd3:    return 16384;
            3'd4:    return 24576;
            3'd5:    return 32764;
            default: return 0;
        endcase
    endfunction

    // Region 5 is a 4-sample region at the top of the ROM.
    function automatic int unsigned region_len(input logic [2:0] r);
        case (r)
            3'd2:    return 8192;
            3'd3:    return 8192;
            3'd4:    return 8188;
            3'd5:    return 4;
            default: return 4096;
        endcase
    endfunction

    function automatic int unsigned presc_step(input logic [1:0] s);
        case (s)
            2'd0:    return 12714;
            2'd1:    return 12000;
            2'd2:    return 11327;
            default: return 10691;
        endcase
    endfunction

endpackage

// File: rtl/synth_voice.sv
// One playback voice: IDLE/PLAY state, pitch prescaler and ROM position
// within the sample region chosen by the note.
module synth_voice
    import synth_pkg::*;
#(
    parameter int POS_W   = 15,
    parameter int PRESC_W = 16,
    parameter int LOOP    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [6:0]       note,
    output logic             playing,
    output logic [POS_W-1:0] pos
);

    voice_state_t         state_q, state_d;
    logic [POS_W-1:0]     pos_q, pos_d, base_q, base_d, end_q, end_d;
    logic [PRESC_W-1:0]   presc_q, presc_d, cnt_q, cnt_d;
    logic [2:0]           region;
    logic                 octave_unused;

    assign region        = region_index({note[4], note[3:2]});
    assign octave_unused = ^note[6:5];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= V_IDLE;
            pos_q   <= '0;
            base_q  <= '0;
            end_q   <= '0;
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            base_q  <= base_d;
            end_q   <= end_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        base_d  = base_q;
        end_d   = end_q;
        presc_d = presc_q;
        cnt_d   = cnt_q;
        if (stop) begin
            state_d = V_IDLE;
        end else if (start) begin
            state_d = V_PLAY;
            base_d  = POS_W'(region_base(region));
            pos_d   = POS_W'(region_base(region));
            end_d   = POS_W'(region_base(region) + region_len(region) - 1);
            presc_d = PRESC_W'(presc_step(note[1:0]));
            cnt_d   = '0;
        end else if (state_q == V_PLAY) begin
            if (cnt_q == presc_q) begin
                cnt_d = '0;
                if (pos_q != end_q)
                    pos_d = pos_q + 1'b1;
                else if (LOOP != 0)
                    pos_d = base_q;
                else
                    state_d = V_IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign playing = (state_q == V_PLAY);
    assign pos     = pos_q;

endmodule

// File: rtl/poly_synthesizer.sv
// Polyphonic sample player: VOICES voices share one synchronous ROM through
// a round-robin slot schedule; one saturated mix is produced per frame.
module poly_synthesizer
    import synth_pkg::*;
#(
    parameter int VOICES   = 4,
    parameter int POS_W    = 15,
    parameter int SAMPLE_W = 8,
    parameter int PRESC_W  = 16,
    parameter int LOOP     = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        stop,
    input  logic [$clog2(VOICES)-1:0]   voice,
    input  logic [6:0]                  note,
    output logic [POS_W-1:0]            rom_addr,
    input  logic signed [SAMPLE_W-1:0]  rom_data,
    output logic signed [SAMPLE_W-1:0]  mix_out,
    output logic                        mix_valid,
    output logic [VOICES-1:0]           active
);

    localparam int VW    = $clog2(VOICES);
    localparam int ACC_W = SAMPLE_W + VW;
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(2 ** (SAMPLE_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-(2 ** (SAMPLE_W - 1)));

    logic [VOICES-1:0]       playing;
    logic [POS_W-1:0]        pos_arr [VOICES];
    logic [VW-1:0]           slot, slot_d, slot_dd;
    logic                    act_d, act_dd;
    logic signed [ACC_W-1:0] acc, add_val, sum;

    for (genvar g = 0; g < VOICES; g++) begin : g_voice
        synth_voice #(
            .POS_W   (POS_W),
            .PRESC_W (PRESC_W),
            .LOOP    (LOOP)
        ) u_voice (
            .clk     (clk),
            .rst     (rst),
            .start   (start && (voice == VW'(g))),
            .stop    (stop && (voice == VW'(g))),
            .note    (note),
            .playing (playing[g]),
            .pos     (pos_arr[g])
        );
    end

    // Slot tag and active flag travel two stages so they line up with the
    // ROM word that returns one cycle after the registered address.
    assign add_val = act_dd ? ACC_W'(rom_data) : '0;
    assign sum     = ((slot_dd == '0) ? '0 : acc) + add_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot      <= '0;
            slot_d    <= '0;
            slot_dd   <= '0;
            act_d     <= 1'b0;
            act_dd    <= 1'b0;
            rom_addr  <= '0;
            acc       <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            active    <= '0;
        end else begin
            slot     <= slot + 1'b1;
            rom_addr <= pos_arr[slot];
            act_d    <= playing[slot];
            slot_d   <= slot;
            act_dd   <= act_d;
            slot_dd  <= slot_d;
            active   <= playing;
            acc      <= sum;
            if (slot_dd == VW'(VOICES - 1)) begin
                mix_valid <= 1'b1;
                if (sum > MAX_V)
                    mix_out <= MAX_V[SAMPLE_W-1:0];
                else if (sum < MIN_V)
                    mix_out <= MIN_V[SAMPLE_W-1:0];
                else
                    mix_out <= sum[SAMPLE_W-1:0];
            end else begin
                mix_valid <= 1'b0;
            end
        end
    end

endmodule
